pulse_monitor: RTL

PULSE_MONITOR -- requirements
Module: pulse_monitor

---
 rtl/pulse_monitor_if.sv | 27 ++
 rtl/pulse_monitor.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pulse_monitor_if.sv
// Bundle of the monitored pulse stream, its clear control and the
// measurement results produced by pulse_monitor.
interface pulse_monitor_if #(
  parameter int CNT_W = 8
);
  logic             pulse_in;
  logic             clr;
  logic             pulse_det;
  logic             len_valid;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] low_len;
  logic             err;
  logic             stuck;
  logic [15:0]      pulse_cnt;

  // Stimulus side: drives the stream and clear, observes the results.
  modport master (
    output pulse_in, clr,
    input  pulse_det, len_valid, high_len, low_len, err, stuck, pulse_cnt
  );

  // Monitor side.
  modport slave (
    input  pulse_in, clr,
    output pulse_det, len_valid, high_len, low_len, err, stuck, pulse_cnt
  );
endinterface

// File: rtl/pulse_monitor.sv
// Pulse stream monitor: measures high/low phase lengths of an already
// synchronous input, compares them with expected lengths, counts rising
// edges and flags saturated (stuck) phases. All outputs are registered.
// The interface instance must be built with the same CNT_W as this module.
module pulse_monitor #(
  parameter int CNT_W    = 8,
  parameter int EXP_HIGH = 1,
  parameter int EXP_LOW  = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  pulse_monitor_if.slave  bus
);

  typedef enum logic [1:0] {
    SINIT = 2'd0,  // waiting for the first low sample
    SLOW  = 2'd1,
    SHIGH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] EXP_H   = CNT_W'(EXP_HIGH);
  localparam logic [CNT_W-1:0] EXP_L   = CNT_W'(EXP_LOW);

  state_t           state_q, state_d;
  logic             primed_q, primed_d;
  logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] pend_low_q, pend_low_d;
  logic [CNT_W-1:0] high_len_q, high_len_d;
  logic [CNT_W-1:0] low_len_q, low_len_d;
  logic             pulse_det_q, pulse_det_d;
  logic             len_valid_q, len_valid_d;
  logic             err_q, err_d;
  logic             stuck_q, stuck_d;
  logic [15:0]      pulse_cnt_q, pulse_cnt_d;
  logic             mismatch;

  // Next-state logic: phase tracking, measurement hand-off and status.
  always_comb begin
    state_d     = state_q;
    primed_d    = primed_q;
    low_cnt_d   = low_cnt_q;
    high_cnt_d  = high_cnt_q;
    pend_low_d  = pend_low_q;
    high_len_d  = high_len_q;
    low_len_d   = low_len_q;
    pulse_det_d = 1'b0;
    len_valid_d = 1'b0;
    mismatch    = 1'b0;

    case (state_q)
      SINIT: begin
        if (!bus.pulse_in) begin
          state_d   = SLOW;
          low_cnt_d = CNT_ONE;
          primed_d  = 1'b0;
        end
      end
      SLOW: begin
        if (bus.pulse_in) begin
          state_d     = SHIGH;
          high_cnt_d  = CNT_ONE;
          pulse_det_d = 1'b1;
          // The low phase before the first complete high is partial.
          if (primed_q) begin
            pend_low_d = low_cnt_q;
          end
        end else if (low_cnt_q != CNT_MAX) begin
          low_cnt_d = low_cnt_q + CNT_ONE;
        end
      end
      SHIGH: begin
        if (!bus.pulse_in) begin
          state_d   = SLOW;
          low_cnt_d = CNT_ONE;
          primed_d  = 1'b1;
          if (primed_q) begin
            high_len_d  = high_cnt_q;
            low_len_d   = pend_low_q;
            len_valid_d = 1'b1;
            // Expected lengths never reach CNT_MAX, so saturation mismatches.
            mismatch    = (high_cnt_q != EXP_H) || (pend_low_q != EXP_L);
          end
        end else if (high_cnt_q != CNT_MAX) begin
          high_cnt_d = high_cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = SINIT;
      end
    endcase

    // Clear wins over a same-cycle edge: that edge is not counted.
    if (bus.clr) begin
      pulse_cnt_d = '0;
    end else if (pulse_det_d && (pulse_cnt_q != 16'hFFFF)) begin
      pulse_cnt_d = pulse_cnt_q + 16'd1;
    end else begin
      pulse_cnt_d = pulse_cnt_q;
    end

    // A fresh mismatch wins over clear so no error is lost.
    if (mismatch) begin
      err_d = 1'b1;
    end else if (bus.clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end

    // Computed from next-state values so STUCK lines up with the counter.
    stuck_d = ((state_d == SLOW)  && (low_cnt_d  == CNT_MAX)) ||
              ((state_d == SHIGH) && (high_cnt_d == CNT_MAX));
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= SINIT;
      primed_q    <= 1'b0;
      low_cnt_q   <= '0;
      high_cnt_q  <= '0;
      pend_low_q  <= '0;
      high_len_q  <= '0;
      low_len_q   <= '0;
      pulse_det_q <= 1'b0;
      len_valid_q <= 1'b0;
      err_q       <= 1'b0;
      stuck_q     <= 1'b0;
      pulse_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      primed_q    <= primed_d;
      low_cnt_q   <= low_cnt_d;
      high_cnt_q  <= high_cnt_d;
      pend_low_q  <= pend_low_d;
      high_len_q  <= high_len_d;
      low_len_q   <= low_len_d;
      pulse_det_q <= pulse_det_d;
      len_valid_q <= len_valid_d;
      err_q       <= err_d;
      stuck_q     <= stuck_d;
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

  assign bus.pulse_det = pulse_det_q;
  assign bus.len_valid = len_valid_q;
  assign bus.high_len  = high_len_q;
  assign bus.low_len   = low_len_q;
  assign bus.err       = err_q;
  assign bus.stuck     = stuck_q;
  assign bus.pulse_cnt = pulse_cnt_q;

endmodule
